udp_port_dispatch: RTL and testbench
====================================

UDP_PORT_DISPATCH -- requirements
Module: udp_port_dispatch

Interface
REQ-001 clock  in  1  single system clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 active  in  1  UDP payload byte valid; high for contiguous bytes of one packet.
REQ-004 data  in  8  payload byte, valid when active=1.
REQ-005 to_port  in  16  destination UDP port; stable while active=1.
REQ-006 ch_ready  in  6  per-channel "can accept one full packet", sampled at packet start only.
REQ-007 ch_wr  out  6  one-hot byte write strobe per channel.
REQ-008 ch_data  out  8  forwarded payload byte; shared by all channels.
REQ-009 ch_sop  out  6  one-hot pulse with the first forwarded byte.
REQ-010 ch_eop  out  6  one-hot single-cycle pulse, cycle after last byte written.
REQ-011 ch_seq  out  32  sequence number of the current or last accepted packet.
REQ-012 drop_count  out  16  packets dropped (unmapped port, not ready, runt); saturating.
REQ-013 seq_err_count  out  16  accepted packets with unexpected sequence; saturating.

Function
REQ-014 Port map: 1024->ch0, 1025->ch1, 1026->ch2, 1027->ch3, 1028->ch4, 1029->ch5; any other port is unmapped.
REQ-015 Packet start is a rising edge of active (active=1, registered active_d=0).
REQ-016 States: IDLE, SEQ, PAYLOAD, DROP.
REQ-017 IDLE, start, port mapped and ch_ready[ch]=1: latch ch, shift data into seq[31:24], go to SEQ with byte index 1.
REQ-018 IDLE, start, port unmapped or ch_ready[ch]=0: go to DROP; increment drop_count.
REQ-019 SEQ: bytes 1..3 complete seq, big-endian; after byte 3 go to PAYLOAD; the 4 sequence bytes are never forwarded.
REQ-020 SEQ, active falls before 4 bytes (runt): increment drop_count, go to IDLE, no ch_sop or ch_eop.
REQ-021 On entering PAYLOAD: ch_seq <= seq; compare seq with expected[ch].
REQ-022 If the comparison fails and valid[ch]=1, increment seq_err_count.
REQ-023 On entering PAYLOAD: expected[ch] <= seq+1 (mod 2^32); valid[ch] <= 1.
REQ-024 PAYLOAD: each active byte produces ch_wr[ch]=1 and ch_data=data one cycle later; latency exactly 1.
REQ-025 PAYLOAD: ch_sop[ch] coincides with the first such write.
REQ-026 PAYLOAD, active falls: ch_eop[ch] pulses on the cycle after the last ch_wr; return to IDLE.
REQ-027 Packet with exactly 4 payload bytes: accepted and sequence-checked; no ch_wr or ch_sop; ch_eop still pulses.
REQ-028 DROP: no outputs asserted; return to IDLE when active=0.
REQ-029 Sequence wrap 0xFFFFFFFF -> 0x00000000 is in order, not an error.
REQ-030 Counters saturate at 0xFFFF, no wrap.
REQ-031 ch_ready changes after packet start do not affect the packet in progress.
REQ-032 At most one bit of ch_wr, ch_sop and ch_eop is set in any cycle.
REQ-033 Back-to-back packets with one idle cycle of active=0 are both handled; eop of the first may coincide with the start-detect of the second.

Reset
REQ-034 Reset sets: state=IDLE; ch_wr, ch_sop, ch_eop = 0.
REQ-035 Reset sets: ch_data, ch_seq, drop_count, seq_err_count, all expected[] = 0; all valid[] = 0.
REQ-036 Reset sets active_d=1, so a packet already in flight is neither forwarded nor counted.
REQ-037 Reset mid-packet: no ch_eop is generated for the aborted packet.

Structure
REQ-038 Shared package holds: port-number constants (1024..1029), NUM_CH=6, channel index width 3, state encoding.
REQ-039 One sub-module, udp_seq_check: holds expected/valid for one channel; instantiated per channel; outputs the mismatch flag.

Verification
REQ-040 Port 1027, ready=1, seq 00000005, 10 payload bytes -> ch_sop[3] with byte 5, ten ch_wr[3], ch_eop[3] next cycle, ch_seq=5.
REQ-041 Two ch1 packets, seq 7 then 9 -> seq_err_count=1.
REQ-042 Two ch1 packets, seq FFFFFFFF then 0 -> seq_err_count=0.
REQ-043 Port 2000, and port 1024 with ch_ready[0]=0 -> no ch_wr, drop_count=2.
REQ-044 3-byte runt on port 1025 -> drop_count+1, no ch_sop or ch_eop.
REQ-045 Reset asserted mid-payload with active still high -> no further ch_wr, no ch_eop; next packet forwarded normally.
REQ-046 0x10000 dropped packets -> drop_count holds 0xFFFF.

Source files
------------

// File: rtl/udp_port_dispatch_pkg.sv
// Shared constants, state encoding and port lookup for the UDP port dispatcher.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package udp_port_dispatch_pkg;

    localparam int NUM_CH = 6;
    localparam int CH_W   = 3;

    localparam logic [15:0] PORT_CH0 = 16'd1024;
    localparam logic [15:0] PORT_CH1 = 16'd1025;
    localparam logic [15:0] PORT_CH2 = 16'd1026;
    localparam logic [15:0] PORT_CH3 = 16'd1027;
    localparam logic [15:0] PORT_CH4 = 16'd1028;
    localparam logic [15:0] PORT_CH5 = 16'd1029;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEQ,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    // Returns {hit, channel}; hit=0 means the port is unmapped.
    function automatic logic [CH_W:0] port_lookup(input logic [15:0] port);
        logic [CH_W:0] r;
        r = '0;
        case (port)
            PORT_CH0: r = {1'b1, 3'd0};
            PORT_CH1: r = {1'b1, 3'd1};
            PORT_CH2: r = {1'b1, 3'd2};
            PORT_CH3: r = {1'b1, 3'd3};
            PORT_CH4: r = {1'b1, 3'd4};
            PORT_CH5: r = {1'b1, 3'd5};
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] one;
        one = NUM_CH'(1);
        return one << ch;
    endfunction

endpackage

// File: rtl/udp_seq_check.sv
// Per-channel sequence tracker: holds the next expected sequence number and a valid flag.
// Latency: mismatch is combinational on seq_in; expected/valid update on load.
// Backpressure: none; load is a single-cycle strobe.
module udp_seq_check
    import udp_port_dispatch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seq_in,
    output logic        mismatch
);

    logic [31:0] expected_q, expected_d;
    logic        valid_q, valid_d;

    always_comb begin
        expected_d = expected_q;
        valid_d    = valid_q;
        if (load) begin
            expected_d = seq_in + 32'd1;
            valid_d    = 1'b1;
        end
    end

    // The first packet on a channel only seeds the tracker and is never an error.
    assign mismatch = valid_q && (seq_in != expected_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            expected_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            expected_q <= expected_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/udp_port_dispatch.sv
// Steers UDP payload bytes to one of six channels by destination port, stripping a 4-byte sequence header.
// Latency: 1 cycle from payload byte in to ch_wr/ch_data out; eop one cycle after the last write.
// Backpressure: none mid-packet; ch_ready is sampled once at packet start, otherwise the packet is dropped.
module udp_port_dispatch
    import udp_port_dispatch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        active,
    input  logic [7:0]  data,
    input  logic [15:0] to_port,
    input  logic [5:0]  ch_ready,
    output logic [5:0]  ch_wr,
    output logic [7:0]  ch_data,
    output logic [5:0]  ch_sop,
    output logic [5:0]  ch_eop,
    output logic [31:0] ch_seq,
    output logic [15:0] drop_count,
    output logic [15:0] seq_err_count
);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       seq_q, seq_d;
    logic              first_q, first_d;
    logic              active_d_q;
    logic [NUM_CH-1:0] ch_wr_q, ch_wr_d;
    logic [7:0]        ch_data_q, ch_data_d;
    logic [NUM_CH-1:0] ch_sop_q, ch_sop_d;
    logic [NUM_CH-1:0] ch_eop_q, ch_eop_d;
    logic [31:0]       ch_seq_q, ch_seq_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic [15:0]       seq_err_count_q, seq_err_count_d;

    logic              start;
    logic [CH_W:0]     lookup;
    logic [31:0]       seq_full;
    logic              drop_inc;
    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] mismatch_vec;

    assign start    = active && !active_d_q;
    assign lookup   = port_lookup(to_port);
    assign seq_full = {seq_q[23:0], data};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_seq
        udp_seq_check u_seq_check (
            .clock    (clock),
            .reset    (reset),
            .load     (load_vec[c]),
            .seq_in   (seq_full),
            .mismatch (mismatch_vec[c])
        );
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        first_d   = first_q;
        ch_wr_d   = '0;
        ch_data_d = ch_data_q;
        ch_sop_d  = '0;
        ch_eop_d  = '0;
        ch_seq_d  = ch_seq_q;
        drop_inc  = 1'b0;
        load_vec  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lookup[CH_W] && ch_ready[lookup[CH_W-1:0]]) begin
                        ch_d    = lookup[CH_W-1:0];
                        seq_d   = {24'd0, data};
                        idx_d   = 2'd1;
                        state_d = ST_SEQ;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = ST_DROP;
                    end
                end
            end
            ST_SEQ: begin
                if (!active) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                end else if (idx_q == 2'd3) begin
                    ch_seq_d = seq_full;
                    load_vec = ch_onehot(ch_q);
                    first_d  = 1'b1;
                    state_d  = ST_PAYLOAD;
                end else begin
                    seq_d = seq_full;
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_PAYLOAD: begin
                if (active) begin
                    ch_wr_d   = ch_onehot(ch_q);
                    ch_data_d = data;
                    ch_sop_d  = first_q ? ch_onehot(ch_q) : '0;
                    first_d   = 1'b0;
                end else begin
                    ch_eop_d = ch_onehot(ch_q);
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drop_count_d = drop_count_q;
        if (drop_inc && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        seq_err_count_d = seq_err_count_q;
        if (|(load_vec & mismatch_vec) && seq_err_count_q != 16'hFFFF) begin
            seq_err_count_d = seq_err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ch_q            <= '0;
            idx_q           <= '0;
            seq_q           <= '0;
            first_q         <= 1'b0;
            // Held high so a packet already in flight when reset lifts is ignored.
            active_d_q      <= 1'b1;
            ch_wr_q         <= '0;
            ch_data_q       <= '0;
            ch_sop_q        <= '0;
            ch_eop_q        <= '0;
            ch_seq_q        <= '0;
            drop_count_q    <= '0;
            seq_err_count_q <= '0;
        end else begin
            state_q         <= state_d;
            ch_q            <= ch_d;
            idx_q           <= idx_d;
            seq_q           <= seq_d;
            first_q         <= first_d;
            active_d_q      <= active;
            ch_wr_q         <= ch_wr_d;
            ch_data_q       <= ch_data_d;
            ch_sop_q        <= ch_sop_d;
            ch_eop_q        <= ch_eop_d;
            ch_seq_q        <= ch_seq_d;
            drop_count_q    <= drop_count_d;
            seq_err_count_q <= seq_err_count_d;
        end
    end

    assign ch_wr         = ch_wr_q;
    assign ch_data       = ch_data_q;
    assign ch_sop        = ch_sop_q;
    assign ch_eop        = ch_eop_q;
    assign ch_seq        = ch_seq_q;
    assign drop_count    = drop_count_q;
    assign seq_err_count = seq_err_count_q;

endmodule

// File: tb/tb_udp_port_dispatch.sv
// Directed self-checking bench for udp_port_dispatch.
module tb_udp_port_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        active;
    logic [7:0]  data;
    logic [15:0] to_port;
    logic [5:0]  ch_ready;
    logic [5:0]  ch_wr;
    logic [7:0]  ch_data;
    logic [5:0]  ch_sop;
    logic [5:0]  ch_eop;
    logic [31:0] ch_seq;
    logic [15:0] drop_count;
    logic [15:0] seq_err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    udp_port_dispatch dut (
        .clock         (clock),
        .reset         (reset),
        .active        (active),
        .data          (data),
        .to_port       (to_port),
        .ch_ready      (ch_ready),
        .ch_wr         (ch_wr),
        .ch_data       (ch_data),
        .ch_sop        (ch_sop),
        .ch_eop        (ch_eop),
        .ch_seq        (ch_seq),
        .drop_count    (drop_count),
        .seq_err_count (seq_err_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int         wr_cnt[6];
    int         sop_cnt[6];
    int         eop_cnt[6];
    int         last_wr_cyc[6];
    int         eop_cyc[6];
    int         sop_cyc[6];
    logic [7:0] sop_byte[6];
    logic [7:0] wr_log[256];
    int         wr_total = 0;
    int         onehot_viol = 0;

    initial begin
        for (int c = 0; c < 6; c++) begin
            wr_cnt[c] = 0; sop_cnt[c] = 0; eop_cnt[c] = 0;
            last_wr_cyc[c] = 0; eop_cyc[c] = 0; sop_cyc[c] = 0; sop_byte[c] = 8'h00;
        end
    end

    always @(negedge clock) begin
        if ($countones(ch_wr) > 1 || $countones(ch_sop) > 1 || $countones(ch_eop) > 1)
            onehot_viol++;
        for (int c = 0; c < 6; c++) begin
            if (ch_wr[c]) begin
                wr_cnt[c]++;
                last_wr_cyc[c] = cyc;
                wr_log[wr_total % 256] = ch_data;
                wr_total++;
            end
            if (ch_sop[c]) begin
                sop_cnt[c]++;
                sop_cyc[c]  = cyc;
                sop_byte[c] = ch_data;
            end
            if (ch_eop[c]) begin
                eop_cnt[c]++;
                eop_cyc[c] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; active = 1'b0; data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // 4 sequence bytes then npay payload bytes (pay_base+i); ch_ready switches to rdy_after once started.
    task automatic send_pkt(input logic [15:0] port, input logic [31:0] seq, input int npay,
                            input logic [7:0] pay_base, input logic [5:0] rdy_after,
                            input int idle_after, output int first_cyc);
        to_port = port;
        for (int i = 0; i < 4; i++) begin
            data   = seq[8*(3-i) +: 8];
            active = 1'b1;
            if (i == 1) ch_ready = rdy_after;
            tick();
        end
        first_cyc = cyc;
        for (int i = 0; i < npay; i++) begin
            data = pay_base + 8'(i);
            tick();
        end
        active = 1'b0;
        data   = 8'h00;
        repeat (idle_after) tick();
    endtask

    task automatic send_raw(input logic [15:0] port, input int n);
        to_port = port;
        for (int i = 0; i < n; i++) begin
            data = 8'hC0 + 8'(i); active = 1'b1;
            tick();
        end
        active = 1'b0; data = 8'h00;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        int w3;
        reset = 1'b1; active = 1'b0; data = 8'h00; to_port = 16'd0; ch_ready = 6'h3F;
        tick(); tick();
        n_cmp++; if (ch_wr !== 6'h00) begin n_fail++; $display("FAIL rst_ch_wr got %h want 00", ch_wr); end
        n_cmp++; if (ch_sop !== 6'h00 || ch_eop !== 6'h00) begin n_fail++; $display("FAIL rst_sop_eop got %h/%h want 00/00", ch_sop, ch_eop); end
        n_cmp++; if (ch_data !== 8'h00) begin n_fail++; $display("FAIL rst_ch_data got %h want 00", ch_data); end
        n_cmp++; if (ch_seq !== 32'h0) begin n_fail++; $display("FAIL rst_ch_seq got %h want 0", ch_seq); end
        n_cmp++; if (drop_count !== 16'h0 || seq_err_count !== 16'h0) begin n_fail++; $display("FAIL rst_counts got %h/%h want 0/0", drop_count, seq_err_count); end
        // A packet already in flight when reset lifts must be ignored entirely.
        w3 = wr_cnt[3];
        to_port = 16'd1027; active = 1'b1; data = 8'h11;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        active = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (wr_cnt[3] != w3) begin n_fail++; $display("FAIL rst_inflight_wr got %0d want 0", wr_cnt[3] - w3); end
        n_cmp++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL rst_inflight_drop got %h want 0", drop_count); end
    endtask

    task automatic test_basic();
        int w3, s3, e3, t0, fc;
        w3 = wr_cnt[3]; s3 = sop_cnt[3]; e3 = eop_cnt[3]; t0 = wr_total;
        ch_ready = 6'h3F;
        send_pkt(16'd1027, 32'h00000005, 10, 8'h10, 6'h3F, 3, fc);
        n_cmp++; if (wr_cnt[3] - w3 != 10) begin n_fail++; $display("FAIL basic_wr_cnt got %0d want 10", wr_cnt[3] - w3); end
        n_cmp++; if (wr_total - t0 != 10) begin n_fail++; $display("FAIL basic_wr_other got %0d total want 10", wr_total - t0); end
        n_cmp++; if (sop_cnt[3] - s3 != 1 || sop_byte[3] !== 8'h10) begin n_fail++; $display("FAIL basic_sop got %0d/%h want 1/10", sop_cnt[3] - s3, sop_byte[3]); end
        n_cmp++; if (sop_cyc[3] != fc + 1) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", sop_cyc[3], fc + 1); end
        n_cmp++; if (eop_cnt[3] - e3 != 1 || eop_cyc[3] != last_wr_cyc[3] + 1) begin n_fail++; $display("FAIL basic_eop got %0d@%0d want 1@%0d", eop_cnt[3] - e3, eop_cyc[3], last_wr_cyc[3] + 1); end
        n_cmp++; if (ch_seq !== 32'h5) begin n_fail++; $display("FAIL basic_ch_seq got %h want 5", ch_seq); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (wr_log[(t0 + i) % 256] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, wr_log[(t0 + i) % 256], 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_seq_err();
        int fc;
        do_reset();
        ch_ready = 6'h3F;
        send_pkt(16'd1025, 32'd7, 2, 8'h20, 6'h3F, 3, fc);
        send_pkt(16'd1025, 32'd9, 2, 8'h30, 6'h3F, 3, fc);
        n_cmp++; if (seq_err_count !== 16'd1) begin n_fail++; $display("FAIL seqerr_count got %0d want 1", seq_err_count); end
        n_cmp++; if (ch_seq !== 32'd9) begin n_fail++; $display("FAIL seqerr_ch_seq got %h want 9", ch_seq); end
    endtask

    task automatic test_seq_wrap();
        int fc;
        do_reset();
        ch_ready = 6'h3F;
        send_pkt(16'd1025, 32'hFFFFFFFF, 1, 8'h40, 6'h3F, 3, fc);
        send_pkt(16'd1025, 32'h00000000, 1, 8'h41, 6'h3F, 3, fc);
        n_cmp++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL wrap_count got %0d want 0", seq_err_count); end
        send_pkt(16'd1025, 32'h00000005, 1, 8'h42, 6'h3F, 3, fc);
        n_cmp++; if (seq_err_count !== 16'd1) begin n_fail++; $display("FAIL wrap_after_gap got %0d want 1", seq_err_count); end
    endtask

    task automatic test_drop();
        int t0, fc;
        do_reset();
        t0 = wr_total;
        ch_ready = 6'h3F;
        send_pkt(16'd2000, 32'd1, 3, 8'h50, 6'h3F, 3, fc);
        ch_ready = 6'h3E;
        send_pkt(16'd1024, 32'd1, 3, 8'h60, 6'h3E, 3, fc);
        n_cmp++; if (wr_total != t0) begin n_fail++; $display("FAIL drop_wr got %0d want 0", wr_total - t0); end
        n_cmp++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL drop_count got %0d want 2", drop_count); end
    endtask

    task automatic test_runt();
        int s1, e1;
        do_reset();
        s1 = sop_cnt[1]; e1 = eop_cnt[1];
        ch_ready = 6'h3F;
        send_raw(16'd1025, 3);
        n_cmp++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL runt_drop got %0d want 1", drop_count); end
        n_cmp++; if (sop_cnt[1] != s1 || eop_cnt[1] != e1) begin n_fail++; $display("FAIL runt_sop_eop got %0d/%0d want 0/0", sop_cnt[1] - s1, eop_cnt[1] - e1); end
    endtask

    task automatic test_four_byte();
        int w4, s4, e4, fc;
        do_reset();
        w4 = wr_cnt[4]; s4 = sop_cnt[4]; e4 = eop_cnt[4];
        ch_ready = 6'h3F;
        send_pkt(16'd1028, 32'd20, 0, 8'h00, 6'h3F, 3, fc);
        n_cmp++; if (wr_cnt[4] != w4 || sop_cnt[4] != s4) begin n_fail++; $display("FAIL four_wr_sop got %0d/%0d want 0/0", wr_cnt[4] - w4, sop_cnt[4] - s4); end
        n_cmp++; if (eop_cnt[4] - e4 != 1 || eop_cyc[4] != fc + 1) begin n_fail++; $display("FAIL four_eop got %0d@%0d want 1@%0d", eop_cnt[4] - e4, eop_cyc[4], fc + 1); end
        n_cmp++; if (ch_seq !== 32'd20) begin n_fail++; $display("FAIL four_ch_seq got %h want 14", ch_seq); end
        send_pkt(16'd1028, 32'd21, 2, 8'h70, 6'h3F, 3, fc);
        n_cmp++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL four_inorder got %0d want 0", seq_err_count); end
        send_pkt(16'd1028, 32'd21, 1, 8'h78, 6'h3F, 3, fc);
        n_cmp++; if (seq_err_count !== 16'd1) begin n_fail++; $display("FAIL four_repeat got %0d want 1", seq_err_count); end
    endtask

    task automatic test_ready_change();
        int w0, fc;
        do_reset();
        w0 = wr_cnt[0];
        ch_ready = 6'h3F;
        send_pkt(16'd1024, 32'd0, 3, 8'h80, 6'h00, 3, fc);
        n_cmp++; if (wr_cnt[0] - w0 != 3) begin n_fail++; $display("FAIL rdy_fall_wr got %0d want 3", wr_cnt[0] - w0); end
        w0 = wr_cnt[0];
        ch_ready = 6'h00;
        send_pkt(16'd1024, 32'd1, 3, 8'h90, 6'h3F, 3, fc);
        n_cmp++; if (wr_cnt[0] != w0 || drop_count !== 16'd1) begin n_fail++; $display("FAIL rdy_rise got wr %0d drop %0d want 0/1", wr_cnt[0] - w0, drop_count); end
    endtask

    task automatic test_back_to_back();
        int w2, w5, e2, e5, fc;
        do_reset();
        w2 = wr_cnt[2]; w5 = wr_cnt[5]; e2 = eop_cnt[2]; e5 = eop_cnt[5];
        ch_ready = 6'h3F;
        send_pkt(16'd1026, 32'd3, 3, 8'hA0, 6'h3F, 1, fc);
        send_pkt(16'd1029, 32'd8, 2, 8'hB0, 6'h3F, 3, fc);
        n_cmp++; if (wr_cnt[2] - w2 != 3 || eop_cnt[2] - e2 != 1) begin n_fail++; $display("FAIL b2b_first got wr %0d eop %0d want 3/1", wr_cnt[2] - w2, eop_cnt[2] - e2); end
        n_cmp++; if (wr_cnt[5] - w5 != 2 || eop_cnt[5] - e5 != 1) begin n_fail++; $display("FAIL b2b_second got wr %0d eop %0d want 2/1", wr_cnt[5] - w5, eop_cnt[5] - e5); end
        n_cmp++; if (sop_byte[5] !== 8'hB0 || ch_seq !== 32'd8) begin n_fail++; $display("FAIL b2b_sop_seq got %h/%h want b0/8", sop_byte[5], ch_seq); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL b2b_drop got %0d want 0", drop_count); end
    endtask

    task automatic test_reset_mid();
        int w3, s3, e3, fc;
        do_reset();
        w3 = wr_cnt[3]; s3 = sop_cnt[3]; e3 = eop_cnt[3];
        ch_ready = 6'h3F; to_port = 16'd1027; active = 1'b1;
        data = 8'h00; tick(); data = 8'h00; tick(); data = 8'h00; tick(); data = 8'h01; tick();
        data = 8'h55; tick(); data = 8'h56; tick();
        data = 8'h57; reset = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin data = 8'h58 + 8'(i); tick(); end
        active = 1'b0; data = 8'h00;
        tick(); tick(); tick();
        n_cmp++; if (wr_cnt[3] - w3 != 2 || sop_cnt[3] - s3 != 1) begin n_fail++; $display("FAIL rstmid_wr got %0d/%0d want 2/1", wr_cnt[3] - w3, sop_cnt[3] - s3); end
        n_cmp++; if (eop_cnt[3] != e3) begin n_fail++; $display("FAIL rstmid_eop got %0d want 0", eop_cnt[3] - e3); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop got %0d want 0", drop_count); end
        w3 = wr_cnt[3]; e3 = eop_cnt[3];
        send_pkt(16'd1027, 32'd100, 3, 8'hD0, 6'h3F, 3, fc);
        n_cmp++; if (wr_cnt[3] - w3 != 3 || eop_cnt[3] - e3 != 1) begin n_fail++; $display("FAIL rstmid_next got wr %0d eop %0d want 3/1", wr_cnt[3] - w3, eop_cnt[3] - e3); end
        n_cmp++; if (ch_seq !== 32'd100 || seq_err_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_seq got %h/%0d want 64/0", ch_seq, seq_err_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        // Preload the counter near its ceiling rather than replaying 64K drops.
        force dut.drop_count_q = 16'hFFFD;
        #2;
        release dut.drop_count_q;
        tick();
        send_raw(16'd2000, 1);
        n_cmp++; if (drop_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_step got %h want fffe", drop_count); end
        send_raw(16'd2000, 1);
        send_raw(16'd2000, 2);
        n_cmp++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", drop_count); end
        send_raw(16'd1024 + 16'd7, 1);
        n_cmp++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_nowrap got %h want ffff", drop_count); end
    endtask

    task automatic test_onehot();
        n_cmp++; if (onehot_viol != 0) begin n_fail++; $display("FAIL onehot got %0d violating cycles want 0", onehot_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq_err();
        test_seq_wrap();
        test_drop();
        test_runt();
        test_four_byte();
        test_ready_change();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_onehot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
